// File: rtl/sram1_arbiter.sv
// sram1_arbiter: round-robin arbiter and single-access sequencer in front of
// the sram1 on-chip memory. Each accepted request drives the SRAM for one
// cycle (ACCESS) and returns a one-cycle response to its owner (RESP).
// Addresses outside [BASE, BASE+SIZE) never touch the array and complete
// with an error response.
module sram1_arbiter #(
  parameter logic [31:0] BASE = 32'h2000_0000,
  parameter logic [31:0] SIZE = 32'h0001_8000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic        p0_req_write,
  input  logic [31:0] p0_req_addr,
  input  logic [31:0] p0_req_wdata,
  output logic        p0_rsp_valid,
  output logic [31:0] p0_rsp_rdata,
  output logic        p0_rsp_error,
  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic        p1_req_write,
  input  logic [31:0] p1_req_addr,
  input  logic [31:0] p1_req_wdata,
  output logic        p1_rsp_valid,
  output logic [31:0] p1_rsp_rdata,
  output logic        p1_rsp_error,
  output logic        sram_read_write,
  output logic [31:0] sram_address,
  output logic [31:0] sram_data_in,
  input  logic [31:0] sram_data_out
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_last_grant;
  logic        r_owner;
  logic        r_write;
  logic        r_in_range;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        w_arb_en;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_accept;
  logic        w_sel_write;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_sel_in_range;
  logic        w_rsp;
  logic        w_rd_hit;

  // Arbitration, request mux and next-state selection.
  always_comb begin
    w_state_nxt    = r_state;
    w_arb_en       = (r_state == S_IDLE) || (r_state == S_RESP);
    // A tie goes to the port that did not win last time.
    w_grant0       = w_arb_en && p0_req_valid && (!p1_req_valid || r_last_grant);
    w_grant1       = w_arb_en && p1_req_valid && (!p0_req_valid || !r_last_grant);
    w_accept       = w_grant0 || w_grant1;
    w_sel_write    = w_grant1 ? p1_req_write : p0_req_write;
    w_sel_addr     = w_grant1 ? p1_req_addr  : p0_req_addr;
    w_sel_wdata    = w_grant1 ? p1_req_wdata : p0_req_wdata;
    // Unsigned wrap makes addresses below BASE land far above SIZE.
    w_sel_in_range = (w_sel_addr - BASE) < SIZE;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_ACCESS;
      S_ACCESS: w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = w_accept ? S_ACCESS : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Command capture on acceptance; r_addr/r_wdata only change when entering
  // ACCESS, so the SRAM address/data buses hold their value elsewhere.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_write      <= 1'b0;
      r_in_range   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else if (w_accept) begin
      r_last_grant <= w_grant1;
      r_owner      <= w_grant1;
      r_write      <= w_sel_write;
      r_in_range   <= w_sel_in_range;
      r_addr       <= w_sel_addr;
      r_wdata      <= w_sel_wdata;
    end
  end

  assign p0_req_ready    = w_grant0;
  assign p1_req_ready    = w_grant1;

  assign sram_read_write = (r_state == S_ACCESS) && r_write && r_in_range;
  assign sram_address    = r_addr;
  assign sram_data_in    = r_wdata;

  assign w_rsp           = (r_state == S_RESP);
  assign w_rd_hit        = w_rsp && !r_write && r_in_range;

  assign p0_rsp_valid    = w_rsp && !r_owner;
  assign p1_rsp_valid    = w_rsp &&  r_owner;
  assign p0_rsp_error    = p0_rsp_valid && !r_in_range;
  assign p1_rsp_error    = p1_rsp_valid && !r_in_range;
  assign p0_rsp_rdata    = (w_rd_hit && !r_owner) ? sram_data_out : '0;
  assign p1_rsp_rdata    = (w_rd_hit &&  r_owner) ? sram_data_out : '0;

endmodule

// File: tb/tb_sram1_arbiter.sv
// tb_sram1_arbiter: directed and randomized traffic on both ports, with a
// behavioural SRAM and a transaction-level reference model that predicts
// grants, SRAM write strobes and per-port responses cycle by cycle.
module tb_sram1_arbiter;

  localparam logic [31:0] BASE = 32'h2000_0000;
  localparam logic [31:0] SIZE = 32'h0001_8000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        p0_req_valid = 1'b0, p1_req_valid = 1'b0;
  logic        p0_req_ready, p1_req_ready;
  logic        p0_req_write = 1'b0, p1_req_write = 1'b0;
  logic [31:0] p0_req_addr = '0, p1_req_addr = '0;
  logic [31:0] p0_req_wdata = '0, p1_req_wdata = '0;
  logic        p0_rsp_valid, p1_rsp_valid;
  logic [31:0] p0_rsp_rdata, p1_rsp_rdata;
  logic        p0_rsp_error, p1_rsp_error;
  logic        sram_read_write;
  logic [31:0] sram_address, sram_data_in;
  logic [31:0] sram_data_out = '0;

  sram1_arbiter #(.BASE(BASE), .SIZE(SIZE)) dut (
    .clock(clock), .reset_n(reset_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
    .p0_req_write(p0_req_write), .p0_req_addr(p0_req_addr),
    .p0_req_wdata(p0_req_wdata), .p0_rsp_valid(p0_rsp_valid),
    .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_error(p0_rsp_error),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
    .p1_req_write(p1_req_write), .p1_req_addr(p1_req_addr),
    .p1_req_wdata(p1_req_wdata), .p1_rsp_valid(p1_rsp_valid),
    .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_error(p1_rsp_error),
    .sram_read_write(sram_read_write), .sram_address(sram_address),
    .sram_data_in(sram_data_in), .sram_data_out(sram_data_out)
  );

  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  function automatic void chk(input bit ok, input string name,
                              input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural SRAM: registered read, write on strobe.
  logic [31:0] smem [logic [31:0]];
  always @(posedge clock) begin
    sram_data_out <= smem.exists(sram_address) ? smem[sram_address] : 32'h0;
    if (sram_read_write) smem[sram_address] = sram_data_in;
  end

  // Reference model: window membership computed with wide arithmetic.
  function automatic bit in_win(input logic [31:0] a);
    return ({32'h0, a} >= {32'h0, BASE}) && ({32'h0, a} < ({32'h0, BASE} + {32'h0, SIZE}));
  endfunction

  typedef struct { int unsigned due; logic [31:0] rdata; logic err; } rsp_t;
  typedef struct { int unsigned due; logic [31:0] addr; logic [31:0] data; } stb_t;

  rsp_t        qr [2][$];
  stb_t        sq [$];
  logic [31:0] model_mem [logic [31:0]];
  int unsigned mcyc = 0;
  int          m_last = 1;
  bit          m_blocked = 1'b0;

  // Monitor and scoreboard: every cycle predicts ready, strobe and responses.
  always @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      qr[0].delete(); qr[1].delete(); sq.delete();
      m_last    = 1;
      m_blocked = 1'b0;
    end else begin
      bit          exp_we, v, e, w, inr;
      logic [31:0] d, a, wd;
      rsp_t        r;
      int          eg;
      logic [1:0]  exp_rdy;
      mcyc++;
      exp_we = (sq.size() > 0) && (sq[0].due == mcyc);
      chk(sram_read_write === exp_we, "sram_we", 64'(sram_read_write), 64'(exp_we));
      if (exp_we) begin
        chk(sram_address === sq[0].addr, "sram_addr", 64'(sram_address), 64'(sq[0].addr));
        chk(sram_data_in === sq[0].data, "sram_wdata", 64'(sram_data_in), 64'(sq[0].data));
        model_mem[sq[0].addr] = sq[0].data;
        void'(sq.pop_front());
      end
      for (int p = 0; p < 2; p++) begin
        v = p ? p1_rsp_valid : p0_rsp_valid;
        e = p ? p1_rsp_error : p0_rsp_error;
        d = p ? p1_rsp_rdata : p0_rsp_rdata;
        if (qr[p].size() > 0 && qr[p][0].due == mcyc) begin
          r = qr[p].pop_front();
          chk(v === 1'b1, p ? "p1_rsp_valid" : "p0_rsp_valid", 64'(v), 64'd1);
          chk(d === r.rdata, p ? "p1_rsp_rdata" : "p0_rsp_rdata", 64'(d), 64'(r.rdata));
          chk(e === r.err, p ? "p1_rsp_error" : "p0_rsp_error", 64'(e), 64'(r.err));
        end else begin
          chk({v, e, d} === 34'h0, p ? "p1_rsp_idle" : "p0_rsp_idle", 64'({v, e, d}), 64'd0);
        end
      end
      eg = -1;
      if (!m_blocked) begin
        if (p0_req_valid && p1_req_valid) eg = (m_last == 1) ? 0 : 1;
        else if (p0_req_valid)            eg = 0;
        else if (p1_req_valid)            eg = 1;
      end
      exp_rdy = (eg == 0) ? 2'b01 : (eg == 1) ? 2'b10 : 2'b00;
      chk({p1_req_ready, p0_req_ready} === exp_rdy, "req_ready",
          64'({p1_req_ready, p0_req_ready}), 64'(exp_rdy));
      m_blocked = 1'b0;
      if (eg >= 0) begin
        w   = eg ? p1_req_write : p0_req_write;
        a   = eg ? p1_req_addr  : p0_req_addr;
        wd  = eg ? p1_req_wdata : p0_req_wdata;
        inr = in_win(a);
        if (w && inr) sq.push_back('{due: mcyc + 1, addr: a, data: wd});
        r.due   = mcyc + 2;
        r.err   = !inr;
        r.rdata = (!w && inr) ? (model_mem.exists(a) ? model_mem[a] : 32'h0) : 32'h0;
        qr[eg].push_back(r);
        m_last    = eg;
        m_blocked = 1'b1;
      end
    end
  end

  // Issue one request on port p and hold it until accepted (bounded).
  task automatic req(input int p, input bit w, input logic [31:0] a, input logic [31:0] d);
    bit got = 1'b0;
    int n = 0;
    if (p == 0) begin
      p0_req_write = w; p0_req_addr = a; p0_req_wdata = d; p0_req_valid = 1'b1;
    end else begin
      p1_req_write = w; p1_req_addr = a; p1_req_wdata = d; p1_req_valid = 1'b1;
    end
    while (!got && n < 20) begin
      @(negedge clock);
      got = (p == 0) ? (p0_req_valid && p0_req_ready) : (p1_req_valid && p1_req_ready);
      n++;
    end
    if (!got) chk(1'b0, "accept_timeout", 64'(p), 64'(a));
    @(posedge clock); #1;
    if (p == 0) p0_req_valid = 1'b0;
    else        p1_req_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 32'h2001_7FFC;
      1:       return 32'h2001_7FFF;
      2:       return 32'h2001_8000;
      3:       return 32'h1FFF_FFFC;
      4:       return 32'hFFFF_FFFF;
      default: return BASE + 32'($urandom_range(0, 7)) * 4;
    endcase
  endfunction

  task automatic check_zero_outputs();
    chk({p0_req_ready, p1_req_ready} === 2'b00, "rst_ready", 64'({p0_req_ready, p1_req_ready}), 64'd0);
    chk({p0_rsp_valid, p1_rsp_valid, p0_rsp_error, p1_rsp_error} === 4'h0, "rst_rsp_flags",
        64'({p0_rsp_valid, p1_rsp_valid, p0_rsp_error, p1_rsp_error}), 64'd0);
    chk({p0_rsp_rdata, p1_rsp_rdata} === 64'h0, "rst_rsp_rdata", {p0_rsp_rdata, p1_rsp_rdata}, 64'd0);
    chk(sram_read_write === 1'b0, "rst_sram_we", 64'(sram_read_write), 64'd0);
    chk(sram_address === 32'h0, "rst_sram_addr", 64'(sram_address), 64'd0);
    chk(sram_data_in === 32'h0, "rst_sram_wdata", 64'(sram_data_in), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n = 0;
    bit got = 1'b0;
    #2;
    check_zero_outputs();
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // Write then read, port 1.
    req(1, 1'b1, 32'h2000_0000, 32'h0123_4567);
    req(1, 1'b0, 32'h2000_0000, 32'h0);

    // Window boundaries.
    req(0, 1'b1, 32'h2001_7FFF, 32'h89AB_CDEF);
    req(0, 1'b0, 32'h2001_7FFF, 32'h0);
    req(1, 1'b1, 32'h2001_8000, 32'hFEDC_BA90);
    req(1, 1'b0, 32'h2001_8000, 32'h0);
    req(0, 1'b0, 32'h1FFF_FFFC, 32'h0);
    req(0, 1'b1, 32'h1FFF_FFFC, 32'h1111_2222);

    // Tie arbitration: both ports continuously valid.
    fork
      repeat (4) req(0, 1'b0, 32'h2000_0000, 32'h0);
      repeat (4) req(1, 1'b0, 32'h2000_0004, 32'h0);
    join

    // Single requester, back-to-back.
    for (int unsigned i = 0; i < 4; i++) req(1, 1'b1, BASE + 32'h40 + i * 4, $urandom);

    // Reset during the ACCESS cycle of a write.
    p0_req_write = 1'b1; p0_req_addr = 32'h2000_0010; p0_req_wdata = 32'h5555_5555;
    p0_req_valid = 1'b1;
    while (!got && n < 20) begin
      @(negedge clock);
      got = p0_req_valid && p0_req_ready;
      n++;
    end
    if (!got) chk(1'b0, "accept_timeout", 64'd0, 64'h2000_0010);
    @(posedge clock); #2;
    p0_req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check_zero_outputs();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    fork
      req(0, 1'b0, 32'h2000_0010, 32'h0);
      req(1, 1'b0, 32'h2000_0014, 32'h0);
    join

    // Randomized traffic on both ports.
    fork
      for (int unsigned i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clock);
        #1 req(0, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      end
      for (int unsigned i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clock);
        #1 req(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      end
    join

    repeat (5) @(posedge clock);
    #1;
    chk(qr[0].size() == 0, "p0_rsp_missing", 64'(qr[0].size()), 64'd0);
    chk(qr[1].size() == 0, "p1_rsp_missing", 64'(qr[1].size()), 64'd0);
    chk(sq.size() == 0, "sram_we_missing", 64'(sq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
